// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI address-channel arbiters.
// Holds the FSM state encoding, a few fixed widths and a loop-based
// round-robin search usable wherever a behavioural pick is handy.
package axi_arb_pkg;

   localparam int MAX_M      = 8;   // widest arbiter the helper supports
   localparam int MAX_IW     = 3;   // $clog2(MAX_M)
   localparam int BURST_BITS = 2;   // AXI AxBURST width

   typedef enum logic {ST_IDLE, ST_GRANT} st_e;

   typedef struct packed {
      logic              vld;
      logic [MAX_IW-1:0] idx;
   } rr_res_t;

   // First set bit of elig searched from (last_idx+1) mod n upward, wrapping.
   function automatic rr_res_t rr_pick(input logic [MAX_M-1:0]  elig,
                                       input logic [MAX_IW-1:0] last_idx,
                                       input int                n);
      rr_res_t r;
      int      k;
      r = '0;
      for (int s = 1; s <= MAX_M; s++) begin
         if (s <= n && !r.vld) begin
            k = (int'(last_idx) + s) % n;
            if (elig[k]) begin
               r.vld = 1'b1;
               r.idx = MAX_IW'(k);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin finder. Requests above last_i get first
// priority; the request vector is doubled so the wrap-around search is a
// single lowest-set-bit isolate. Also used by the R/B return arbiters.
module rr_pick_onehot #(
   parameter  int N  = 3,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic          any_o
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] low;

   // mask keeps only indices strictly above the last winner
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) mask[i] = (i > int'(last_i));
   end

   assign dbl   = {req_i, req_i & mask};
   assign low   = dbl & (~dbl + (2*N)'(1));
   assign gnt_o = low[N-1:0] | low[2*N-1:N];
   assign any_o = |req_i;

endmodule

// File: rtl/axi_addr_arbiter_rr.sv
// N-master AXI address-channel arbiter with registered, locked grant and
// round-robin fairness. The grant is held from VALID until the handshake;
// on a handshake the next master is picked in the same edge with the
// current owner excluded, so a lone requester re-wins after one idle cycle.
// Optional build macro ARB_PERF_CNT_EN adds per-master handshake counters
// (grant_cnt) and the longest observed wait (wait_max).
module axi_addr_arbiter_rr
   import axi_arb_pkg::*;
#(
   parameter  int NUM_M     = 3,
   parameter  int ID_BITS   = 4,
   parameter  int PFX_BITS  = 4,
   parameter  int ADDR_BITS = 32,
   parameter  int LEN_BITS  = 4,
   parameter  int SIZE_BITS = 3,
   localparam int IW        = $clog2(NUM_M)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_M*ID_BITS-1:0]      id_m,
   input  logic [NUM_M*ADDR_BITS-1:0]    addr_m,
   input  logic [NUM_M*LEN_BITS-1:0]     len_m,
   input  logic [NUM_M*SIZE_BITS-1:0]    size_m,
   input  logic [NUM_M*BURST_BITS-1:0]   burst_m,
   input  logic [NUM_M-1:0]              valid_m,
   input  logic [NUM_M-1:0]              req_m,
   output logic [NUM_M-1:0]              ready_m,
   output logic [PFX_BITS+ID_BITS-1:0]   id_s,
   output logic [ADDR_BITS-1:0]          addr_s,
   output logic [LEN_BITS-1:0]           len_s,
   output logic [SIZE_BITS-1:0]          size_s,
   output logic [BURST_BITS-1:0]         burst_s,
   output logic                          valid_s,
   input  logic                          ready_s,
   output logic                          grant_vld,
   output logic [IW-1:0]                 grant_idx
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [NUM_M*16-1:0]           grant_cnt,
   output logic [15:0]                   wait_max
`endif
);

   st_e              state_q;
   logic             grant_vld_q;
   logic [IW-1:0]    grant_idx_q;
   logic [IW-1:0]    last_idx_q;

   logic [NUM_M-1:0] elig;
   logic [NUM_M-1:0] pick_req;
   logic [NUM_M-1:0] pick_oh;
   logic             pick_any;
   logic [IW-1:0]    pick_idx;
   logic             g_valid;
   logic             g_elig;
   logic             hs;
   int unsigned      gi;

   assign elig    = valid_m & req_m;
   assign gi      = int'(grant_idx_q);
   assign g_valid = valid_m[grant_idx_q];
   assign g_elig  = elig[grant_idx_q];
   assign hs      = grant_vld_q & g_valid & ready_s;

   // While granted only the handshake edge re-arbitrates, and the owner
   // must sit out that round; last_idx equals the owner in that state.
   assign pick_req = grant_vld_q ? (elig & ~(NUM_M'(1) << grant_idx_q)) : elig;

   rr_pick_onehot #(.N(NUM_M)) u_pick (
      .req_i  (pick_req),
      .last_i (last_idx_q),
      .gnt_o  (pick_oh),
      .any_o  (pick_any)
   );

   // one-hot winner to index
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_M; i++) if (pick_oh[i]) pick_idx = IW'(i);
   end

   // grant FSM: acquire from idle, hold while locked, hand over on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_vld_q <= 1'b0;
         grant_idx_q <= '0;
         last_idx_q  <= IW'(NUM_M - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q     <= ST_GRANT;
                  grant_vld_q <= 1'b1;
                  grant_idx_q <= pick_idx;
                  last_idx_q  <= pick_idx;
               end
            end
            ST_GRANT: begin
               if (hs) begin
                  if (pick_any) begin
                     grant_idx_q <= pick_idx;
                     last_idx_q  <= pick_idx;
                  end else begin
                     state_q     <= ST_IDLE;
                     grant_vld_q <= 1'b0;
                     grant_idx_q <= '0;
                  end
               end else if (!g_elig) begin
                  // owner withdrew before the handshake: drop, keep last_idx
                  state_q     <= ST_IDLE;
                  grant_vld_q <= 1'b0;
                  grant_idx_q <= '0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               grant_vld_q <= 1'b0;
               grant_idx_q <= '0;
            end
         endcase
      end
   end

   // route the owner's channel to the slave; everything quiet when idle
   always_comb begin
      ready_m = '0;
      valid_s = 1'b0;
      id_s    = '0;
      addr_s  = '0;
      len_s   = '0;
      size_s  = '0;
      burst_s = '0;
      if (grant_vld_q) begin
         valid_s              = g_valid;
         ready_m[grant_idx_q] = ready_s;
         id_s    = {PFX_BITS'(grant_idx_q) + PFX_BITS'(1),
                    id_m[gi*ID_BITS +: ID_BITS]};
         addr_s  = addr_m[gi*ADDR_BITS +: ADDR_BITS];
         len_s   = len_m[gi*LEN_BITS +: LEN_BITS];
         size_s  = size_m[gi*SIZE_BITS +: SIZE_BITS];
         burst_s = burst_m[gi*BURST_BITS +: BURST_BITS];
      end
   end

   assign grant_vld = grant_vld_q;
   assign grant_idx = grant_idx_q;

`ifdef ARB_PERF_CNT_EN
   localparam int CNT_BITS = 16;

   logic [NUM_M-1:0][CNT_BITS-1:0] cnt_q;
   logic [NUM_M-1:0][CNT_BITS-1:0] wait_q;
   logic [CNT_BITS-1:0]            wait_max_q;
   logic [CNT_BITS-1:0]            wait_max_d;

   // saturating handshake counts and per-master runs of ungranted waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         wait_q     <= '0;
         wait_max_q <= '0;
      end else begin
         for (int i = 0; i < NUM_M; i++) begin
            if (hs && grant_idx_q == IW'(i) && cnt_q[i] != '1)
               cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
            if (elig[i] && !(grant_vld_q && grant_idx_q == IW'(i))) begin
               if (wait_q[i] != '1) wait_q[i] <= wait_q[i] + CNT_BITS'(1);
            end else begin
               wait_q[i] <= '0;
            end
         end
         wait_max_q <= wait_max_d;
      end
   end

   // running maximum over all masters' current wait runs
   always_comb begin
      wait_max_d = wait_max_q;
      for (int i = 0; i < NUM_M; i++)
         if (wait_q[i] > wait_max_d) wait_max_d = wait_q[i];
   end

   assign grant_cnt = cnt_q;
   assign wait_max  = wait_max_q;
`endif

endmodule
